// File: rtl/conv_axis_packer.sv
// rtl/conv_axis_packer.sv - packs 8-bit conv pixels into 32-bit AXI4-Stream beats through a small beat FIFO
// Optional beat counter output enabled by defining CONV_PACK_STATS_EN; only a 32-bit stream width is supported.
module conv_axis_packer #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH             = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [7:0]                        in_data,
    input  logic                              in_last,
    input  logic                              M_AXIS_TREADY,
    output logic                              M_AXIS_TVALID,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [3:0]                        M_AXIS_TKEEP,
    output logic                              M_AXIS_TLAST,
    output logic                              M_AXIS_TUSER,
    output logic                              pack_busy,
    output logic                              pack_done
`ifdef CONV_PACK_STATS_EN
    ,
    output logic [31:0]                       beat_count
`endif
);

    localparam int DW = C_S00_AXIS_TDATA_WIDTH;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [1:0]    r_lane;
    logic [DW-1:0] r_pack;
    logic          r_first;
    logic          r_busy;
    logic          r_done;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [DW-1:0] r_mem_data [FIFO_DEPTH];
    logic [3:0]    r_mem_keep [FIFO_DEPTH];
    logic          r_mem_last [FIFO_DEPTH];
    logic          r_mem_user [FIFO_DEPTH];

    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_head_last;
    logic [DW-1:0] w_word;
    logic [3:0]    w_keep;

    assign w_full      = (r_count == CW'(FIFO_DEPTH));
    assign w_empty     = (r_count == '0);
    assign w_accept    = in_valid & ~w_full;
    assign w_push      = w_accept & ((r_lane == 2'd3) | in_last);
    assign w_pop       = ~w_empty & M_AXIS_TREADY;
    assign w_head_last = r_mem_last[r_rd_ptr];

    // Lanes above r_lane are already zero because r_pack clears on every push.
    always_comb begin
        w_word = r_pack;
        w_word[{r_lane, 3'b000} +: 8] = in_data;
        w_keep = 4'b0001;
        case (r_lane)
            2'd0: w_keep = 4'b0001;
            2'd1: w_keep = 4'b0011;
            2'd2: w_keep = 4'b0111;
            2'd3: w_keep = 4'b1111;
            default: w_keep = 4'b0001;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_word;
            r_mem_keep[r_wr_ptr] <= w_keep;
            r_mem_last[r_wr_ptr] <= in_last;
            r_mem_user[r_wr_ptr] <= r_first;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane   <= 2'd0;
            r_pack   <= '0;
            r_first  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                if (w_push) begin
                    r_lane <= 2'd0;
                    r_pack <= '0;
                end else begin
                    r_lane <= r_lane + 2'd1;
                    r_pack[{r_lane, 3'b000} +: 8] <= in_data;
                end
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                r_first  <= in_last;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            // A new frame's first pixel wins over the previous frame's TLAST pop.
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (w_pop & w_head_last) begin
                r_busy <= 1'b0;
            end
            r_done <= w_pop & w_head_last;
        end
    end

`ifdef CONV_PACK_STATS_EN
    logic [31:0] r_beat_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat_count <= '0;
        end else if (w_pop) begin
            r_beat_count <= r_beat_count + 32'd1;
        end
    end

    assign beat_count = r_beat_count;
`endif

    assign in_ready      = ~w_full;
    assign M_AXIS_TVALID = ~w_empty;
    assign M_AXIS_TDATA  = w_empty ? '0   : r_mem_data[r_rd_ptr];
    assign M_AXIS_TKEEP  = w_empty ? 4'h0 : r_mem_keep[r_rd_ptr];
    assign M_AXIS_TLAST  = w_empty ? 1'b0 : r_mem_last[r_rd_ptr];
    assign M_AXIS_TUSER  = w_empty ? 1'b0 : r_mem_user[r_rd_ptr];
    assign pack_busy     = r_busy;
    assign pack_done     = r_done;

endmodule

// File: tb/tb_conv_axis_packer.sv
// tb/tb_conv_axis_packer.sv - scoreboard bench for conv_axis_packer
module tb_conv_axis_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        tready;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tkeep;
    logic        tlast;
    logic        tuser;
    logic        pack_busy;
    logic        pack_done;
`ifdef CONV_PACK_STATS_EN
    logic [31:0] beat_count;
`endif

    always #5 clk = ~clk;

    conv_axis_packer #(.C_S00_AXIS_TDATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .M_AXIS_TREADY(tready),
        .M_AXIS_TVALID(tvalid),
        .M_AXIS_TDATA(tdata),
        .M_AXIS_TKEEP(tkeep),
        .M_AXIS_TLAST(tlast),
        .M_AXIS_TUSER(tuser),
        .pack_busy(pack_busy),
        .pack_done(pack_done)
`ifdef CONV_PACK_STATS_EN
        ,
        .beat_count(beat_count)
`endif
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        logic        u;
    } beat_t;

    beat_t exp_q[$];
    int    n_tests   = 0;
    int    n_fail    = 0;
    int    done_seen = 0;
    logic  toggle_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        beat_t b;
        b.d = d; b.k = k; b.l = l; b.u = u;
        exp_q.push_back(b);
    endtask

    // Caller is between edges; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] d, input logic l);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("send_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        if (t >= 300) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (toggle_en) begin
            #1 tready = ~tready;
        end
    end

    // Monitor: scoreboard pops, AXIS hold stability, done timing.
    beat_t hold_b;
    logic  hold_v       = 1'b0;
    logic  prev_lastpop = 1'b0;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            hold_v       = 1'b0;
            prev_lastpop = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_tvalid", 32'(tvalid), 32'd1);
                chk("hold_beat", {tdata ^ hold_b.d, 4'(tkeep ^ hold_b.k), 1'(tlast ^ hold_b.l), 1'(tuser ^ hold_b.u)} != '0 ? 32'd1 : 32'd0, 32'd0);
            end
            if (prev_lastpop || pack_done) chk("pack_done", 32'(pack_done), 32'(prev_lastpop));
            if (pack_done) done_seen++;
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", tdata, 32'hDEADBEEF);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", tdata, e.d);
                    chk("tkeep", 32'(tkeep), 32'(e.k));
                    chk("tlast", 32'(tlast), 32'(e.l));
                    chk("tuser", 32'(tuser), 32'(e.u));
                end
            end
            hold_v       = tvalid && !tready;
            hold_b.d     = tdata;
            hold_b.k     = tkeep;
            hold_b.l     = tlast;
            hold_b.u     = tuser;
            prev_lastpop = tvalid && tready && tlast;
        end
    end

    initial begin
        int d0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        tready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", tdata, 32'd0);
        chk("rst_tkeep", 32'(tkeep), 32'd0);
        chk("rst_tlast_tuser", 32'({tlast, tuser}), 32'd0);
        chk("rst_done_busy", 32'({pack_done, pack_busy}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Two full beats
        tready = 1'b1;
        d0 = done_seen;
        push_exp(32'h04030201, 4'hF, 1'b0, 1'b1);
        push_exp(32'h08070605, 4'hF, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), i == 8);
            if (i == 1) chk("busy_set", 32'(pack_busy), 32'd1);
        end
        drain();
        chk("t1_done_count", 32'(done_seen - d0), 32'd1);
        chk("t1_busy_clear", 32'(pack_busy), 32'd0);

        // Partial final beat with TREADY toggling
        d0 = done_seen;
        push_exp(32'hA3A2A1A0, 4'hF, 1'b0, 1'b1);
        push_exp(32'h000000A4, 4'h1, 1'b1, 1'b0);
        toggle_en = 1'b1;
        for (int i = 0; i < 5; i++) send(8'hA0 + 8'(i), i == 4);
        drain();
        toggle_en = 1'b0;
        #1;
        tready = 1'b1;
        chk("t2_done_count", 32'(done_seen - d0), 32'd1);

        // FIFO fill with TREADY low
        tready = 1'b0;
        d0 = done_seen;
        push_exp(32'h13121110, 4'hF, 1'b0, 1'b1);
        push_exp(32'h17161514, 4'hF, 1'b0, 1'b0);
        push_exp(32'h1B1A1918, 4'hF, 1'b0, 1'b0);
        push_exp(32'h1F1E1D1C, 4'hF, 1'b0, 1'b0);
        push_exp(32'h23222120, 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send(8'h10 + 8'(i), 1'b0);
            if (i == 14) chk("full_ready_15", 32'(in_ready), 32'd1);
        end
        chk("full_ready_16", 32'(in_ready), 32'd0);
        chk("full_tvalid", 32'(tvalid), 32'd1);
        fork
            begin
                repeat (6) @(posedge clk);
                #1 tready = 1'b1;
            end
        join_none
        for (int i = 16; i < 20; i++) send(8'h10 + 8'(i), i == 19);
        drain();
        chk("t3_done_count", 32'(done_seen - d0), 32'd1);

        // Single-pixel frame
        d0 = done_seen;
        push_exp(32'h00000055, 4'h1, 1'b1, 1'b1);
        send(8'h55, 1'b1);
        drain();
        chk("t4_done_count", 32'(done_seen - d0), 32'd1);
        chk("t4_busy_clear", 32'(pack_busy), 32'd0);

        // Reset mid-frame
        tready = 1'b0;
        d0 = done_seen;
        for (int i = 0; i < 6; i++) send(8'h30 + 8'(i), 1'b0);
        chk("t5_tvalid_pre", 32'(tvalid), 32'd1);
        chk("t5_busy_pre", 32'(pack_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_tvalid_post", 32'(tvalid), 32'd0);
        chk("t5_tdata_post", tdata, 32'd0);
        chk("t5_busy_post", 32'(pack_busy), 32'd0);
        chk("t5_ready_post", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_done", 32'(done_seen - d0), 32'd0);
        tready = 1'b1;
        push_exp(32'h43424140, 4'hF, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), i == 3);
        drain();
        chk("t5_done_count", 32'(done_seen - d0), 32'd1);

`ifdef CONV_PACK_STATS_EN
        chk("stats_after_rst", beat_count, 32'd1);
        for (int f = 0; f < 2; f++) begin
            push_exp(32'h63626160, 4'hF, 1'b0, 1'b1);
            push_exp(32'h67666564, 4'hF, 1'b1, 1'b0);
            for (int i = 0; i < 8; i++) send(8'h60 + 8'(i), i == 7);
        end
        drain();
        chk("stats_two_frames", beat_count, 32'd5);
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
